mux_nc1_skid: RTL and testbench
===============================

Name: mux_nc1_skid

Overview:
Parametrised N-way, WIDTH-bit select mux with a registered valid/ready output stage and a 2-entry skid buffer. It replaces the fixed 2:1/3:1 combinational muxes where the selected value must cross a pipeline boundary with backpressure, such as the writeback or forwarding select between stages. An out-of-range select is detected in hardware and reported through a sticky error flag.

Parameters:
WIDTH, 32, data width of each input channel and of dout
N, 3, number of input channels (2..16)
SEL_W, derived localparam = max(1, clog2(N)), width of the select field (not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream offers sel/din this cycle
in_ready  output  1  block can accept this cycle
sel  input  SEL_W  channel index; valid range 0..N-1
din  input  N*WIDTH  flattened channels; channel k = din[k*WIDTH +: WIDTH]
out_valid  output  1  dout/out_sel hold a valid entry
out_ready  input  1  downstream accepts this cycle
dout  output  WIDTH  selected data (head entry)
out_sel  output  SEL_W  channel index that produced dout
err_invalid_sel  output  1  sticky: an out-of-range sel was accepted
err_clr  input  1  synchronous clear of err_invalid_sel

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=EMPTY, out_valid=0, dout=0, out_sel=0, err_invalid_sel=0, all skid contents=0. in_ready=1 once rst_n deasserts.
- Accept condition: in_valid && in_ready. Output handshake: out_valid && out_ready.
- Capture: on accept, the entry {din[sel], sel} is captured. Mux is combinational at the input; the result is registered.
- Latency: an accept in cycle t gives out_valid=1 in cycle t+1.
- Throughput: one transfer per cycle while out_ready=1.
- State machine, on occupancy:
  - EMPTY: accept -> ONE. Otherwise stay.
  - ONE: accept without pop -> TWO (new entry goes to skid). Pop without accept -> EMPTY. Accept and pop together -> ONE (new entry becomes head). Neither -> stay.
  - TWO: pop -> ONE (skid moves to head). No accept is possible in TWO.
- in_ready = (state != TWO). It is a function of state only; no combinational path from out_ready.
- Ordering: strict FIFO. dout/out_sel always show the oldest entry. They are stable while out_valid && !out_ready.
- Invalid select (sel >= N, only possible when N is not a power of 2):
  - The transaction is accepted (in_ready behaviour unchanged) but is dropped and never appears on the output.
  - err_invalid_sel is set on the next edge.
- Error flag: err_clr clears it. If an invalid accept and err_clr occur in the same cycle, set wins.
- Boundaries:
  - Pop from EMPTY is impossible because out_valid=0.
  - Accept in TWO is blocked.
  - A reset assertion mid-transfer discards all entries immediately (async) and returns all outputs to reset values.
- dout/out_sel when out_valid=0: they hold the last popped value, or 0 after reset. They are not X.

Optional Feature:
MUX_ERR_CNT_EN
- Defined: adds output err_cnt [7:0], a saturating count of dropped invalid-sel accepts.
  - Resets to 0; err_clr also clears it.
  - If an increment and err_clr coincide, the count becomes 1.
  - Holds at 255.
- Not defined: the port and counter are absent; only the sticky flag exists.

Decomposition:
- Shared package mux_pkg:
  - state encoding typedef (EMPTY=2'd0, ONE=2'd1, TWO=2'd2)
  - function clog2_min1 for SEL_W
  - constant ERR_CNT_W=8
- One natural sub-module, skid_buf2: a 2-entry, WIDTH+SEL_W-bit valid/ready buffer holding the state machine.
- The top level holds the input mux, range check and error logic.

Test Plan:
- Reset then single transfer: N=3, WIDTH=32, din={32'hC,32'hB,32'hA}, sel=1, in_valid for one cycle, out_ready=1 -> next cycle out_valid=1, dout=32'hB, out_sel=1; following cycle out_valid=0.
- Backpressure fill: out_ready=0, push sel=0 then sel=2 -> in_ready=0 after the second accept, dout=32'hA held. Raise out_ready -> dout=32'hA, then 32'hC on consecutive cycles; in_ready returns to 1.
- Full throughput: in_valid=1 and out_ready=1 for 10 cycles with sel cycling 0,1,2 -> 10 outputs in order, state never leaves ONE, no bubbles.
- Invalid select: N=3, sel=3 accepted -> no output produced, err_invalid_sel=1 next cycle. With MUX_ERR_CNT_EN, err_cnt=1; 300 invalid accepts give err_cnt=255. err_clr in the same cycle as an invalid accept -> flag stays 1.
- Async reset mid-operation: state TWO with out_ready=0, pulse rst_n low between clock edges -> out_valid=0, dout=0, err_invalid_sel=0 immediately; in_ready=1 after release.
- Power-of-2 N=4: sel=3 -> valid transfer of channel 3; err_invalid_sel stays 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the mux_nc1_skid slice: occupancy state
// encoding, select-width helper and error counter width.
package mux_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam int unsigned ERR_CNT_W = 8;

   // Number of bits needed to index n channels, never less than 1.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/mux_nc1_skid_if.sv
// Handshake/bus bundle for mux_nc1_skid. The err_cnt member exists only
// when MUX_ERR_CNT_EN is defined.
interface mux_nc1_skid_if import mux_pkg::*; #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 3
) ();
   localparam int unsigned SEL_W = clog2_min1(N);

   logic                 in_valid;
   logic                 in_ready;
   logic [SEL_W-1:0]     sel;
   logic [N*WIDTH-1:0]   din;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     dout;
   logic [SEL_W-1:0]     out_sel;
   logic                 err_invalid_sel;
   logic                 err_clr;
`ifdef MUX_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt;
`endif

   // Upstream/downstream environment side
   modport master (
      output in_valid, sel, din, out_ready, err_clr,
`ifdef MUX_ERR_CNT_EN
      input  err_cnt,
`endif
      input  in_ready, out_valid, dout, out_sel, err_invalid_sel
   );

   // Mux block side
   modport slave (
      input  in_valid, sel, din, out_ready, err_clr,
`ifdef MUX_ERR_CNT_EN
      output err_cnt,
`endif
      output in_ready, out_valid, dout, out_sel, err_invalid_sel
   );

endinterface

// File: rtl/skid_buf2.sv
// Two-entry valid/ready buffer. Head register drives the output; the skid
// register absorbs one extra entry so in_ready depends on state only.
module skid_buf2 import mux_pkg::*; #(
   parameter int unsigned DW = 34
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_in_valid,
   output logic          o_in_ready,
   input  logic [DW-1:0] i_in_data,
   output logic          o_out_valid,
   input  logic          i_out_ready,
   output logic [DW-1:0] o_out_data
);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [DW-1:0] r_head;
   logic [DW-1:0] r_skid;
   logic          w_push;
   logic          w_pop;
   logic          w_head_ld_in;
   logic          w_head_ld_skid;
   logic          w_skid_ld;

   assign o_in_ready  = (r_state != TWO);
   assign o_out_valid = (r_state != EMPTY);
   assign o_out_data  = r_head;
   assign w_push      = i_in_valid && o_in_ready;
   assign w_pop       = o_out_valid && i_out_ready;

   // Occupancy state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= EMPTY;
      else        r_state <= w_state_nxt;
   end

   // Next-state and register-load decode
   always_comb begin
      w_state_nxt    = r_state;
      w_head_ld_in   = 1'b0;
      w_head_ld_skid = 1'b0;
      w_skid_ld      = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_push) begin
               w_head_ld_in = 1'b1;
               w_state_nxt  = ONE;
            end
         end
         ONE: begin
            if (w_push && w_pop) begin
               w_head_ld_in = 1'b1;
            end else if (w_push) begin
               w_skid_ld   = 1'b1;
               w_state_nxt = TWO;
            end else if (w_pop) begin
               w_state_nxt = EMPTY;
            end
         end
         TWO: begin
            if (w_pop) begin
               w_head_ld_skid = 1'b1;
               w_state_nxt    = ONE;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   // Head/skid data registers; head keeps the last popped entry when empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head <= '0;
         r_skid <= '0;
      end else begin
         if (w_head_ld_in)        r_head <= i_in_data;
         else if (w_head_ld_skid) r_head <= r_skid;
         if (w_skid_ld)           r_skid <= i_in_data;
      end
   end

endmodule

// File: rtl/mux_nc1_skid.sv
// N-way WIDTH-bit select mux feeding a 2-entry skid buffer, with sticky
// detection of out-of-range selects. Optional macro MUX_ERR_CNT_EN adds a
// saturating count of dropped invalid-select accepts.
module mux_nc1_skid import mux_pkg::*; #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   mux_nc1_skid_if.slave bus
);

   localparam int unsigned SEL_W = clog2_min1(N);
   localparam int unsigned DW    = WIDTH + SEL_W;

   logic [WIDTH-1:0] w_mux;
   logic             w_sel_ok;
   logic             w_in_ready;
   logic             w_out_valid;
   logic [DW-1:0]    w_head;
   logic             w_bad_accept;
   logic             r_err;

   assign w_sel_ok     = (32'(bus.sel) < N);
   assign w_bad_accept = bus.in_valid && w_in_ready && !w_sel_ok;

   // Input channel select; out-of-range selects yield zero and are dropped
   always_comb begin
      w_mux = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (bus.sel == SEL_W'(k)) w_mux = bus.din[k*WIDTH +: WIDTH];
      end
   end

   // Invalid selects still consume the handshake but never enter the buffer
   skid_buf2 #(.DW(DW)) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (bus.in_valid && w_sel_ok),
      .o_in_ready  (w_in_ready),
      .i_in_data   ({w_mux, bus.sel}),
      .o_out_valid (w_out_valid),
      .i_out_ready (bus.out_ready),
      .o_out_data  (w_head)
   );

   assign bus.in_ready        = w_in_ready;
   assign bus.out_valid       = w_out_valid;
   assign bus.dout            = w_head[DW-1:SEL_W];
   assign bus.out_sel         = w_head[SEL_W-1:0];
   assign bus.err_invalid_sel = r_err;

   // Sticky invalid-select flag; a new error wins over a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            r_err <= 1'b0;
      else if (w_bad_accept) r_err <= 1'b1;
      else if (bus.err_clr)  r_err <= 1'b0;
   end

`ifdef MUX_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] r_err_cnt;

   assign bus.err_cnt = r_err_cnt;

   // Saturating drop counter; increment with clear restarts at one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt <= '0;
      end else if (w_bad_accept) begin
         if (bus.err_clr)          r_err_cnt <= ERR_CNT_W'(1);
         else if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end else if (bus.err_clr) begin
         r_err_cnt <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_mux_nc1_skid.sv
// Directed bench for mux_nc1_skid: N=3 and N=4 instances, table of
// single-cycle vectors plus hand sequences for saturation and async reset.
module tb_mux_nc1_skid;
   import mux_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mux_nc1_skid_if #(.WIDTH(32), .N(3)) bus3 ();
   mux_nc1_skid_if #(.WIDTH(32), .N(4)) bus4 ();

   mux_nc1_skid #(.WIDTH(32), .N(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
   mux_nc1_skid #(.WIDTH(32), .N(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   typedef struct {
      logic        iv;
      logic [1:0]  sel;
      logic        ordy;
      logic        clr;
      logic        ov;
      logic [31:0] dout;
      logic [1:0]  osel;
      logic        ir;
      logic        err;
      logic [7:0]  cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   function automatic void add(input logic iv, input logic [1:0] sel, input logic ordy,
                               input logic clr, input logic ov, input logic [31:0] dout,
                               input logic [1:0] osel, input logic ir, input logic err,
                               input logic [7:0] cnt);
      vec_t v;
      v.iv = iv; v.sel = sel; v.ordy = ordy; v.clr = clr;
      v.ov = ov; v.dout = dout; v.osel = osel; v.ir = ir; v.err = err; v.cnt = cnt;
      vecs.push_back(v);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive3(input logic iv, input logic [1:0] sel, input logic ordy,
                         input logic clr);
      bus3.in_valid  = iv;
      bus3.sel       = sel;
      bus3.out_ready = ordy;
      bus3.err_clr   = clr;
   endtask

   initial begin
      rst_n = 1'b0;
      drive3(1'b0, 2'd0, 1'b0, 1'b0);
      bus3.din       = {32'hC, 32'hB, 32'hA};
      bus4.in_valid  = 1'b0;
      bus4.sel       = 2'd0;
      bus4.out_ready = 1'b0;
      bus4.err_clr   = 1'b0;
      bus4.din       = {32'hD, 32'hC, 32'hB, 32'hA};

      // Reset state of both instances
      #2;
      chk("rst_ov3",   0, 32'(bus3.out_valid), 32'd0);
      chk("rst_dout3", 0, bus3.dout, 32'd0);
      chk("rst_osel3", 0, 32'(bus3.out_sel), 32'd0);
      chk("rst_err3",  0, 32'(bus3.err_invalid_sel), 32'd0);
      chk("rst_ov4",   0, 32'(bus4.out_valid), 32'd0);
`ifdef MUX_ERR_CNT_EN
      chk("rst_cnt3",  0, 32'(bus3.err_cnt), 32'd0);
`endif
      #10 rst_n = 1'b1;
      #1;
      chk("rst_ir3", 0, 32'(bus3.in_ready), 32'd1);
      chk("rst_ir4", 0, 32'(bus4.in_ready), 32'd1);
      step();

      // Single transfer then drain
      add(1, 1, 1, 0,  1, 32'hB, 1, 1, 0, 0);
      add(0, 0, 1, 0,  0, 32'hB, 1, 1, 0, 0);
      // Backpressure fill to TWO, blocked accept, then drain in order
      add(1, 0, 0, 0,  1, 32'hA, 0, 1, 0, 0);
      add(1, 2, 0, 0,  1, 32'hA, 0, 0, 0, 0);
      add(1, 1, 0, 0,  1, 32'hA, 0, 0, 0, 0);
      add(0, 0, 1, 0,  1, 32'hC, 2, 1, 0, 0);
      add(0, 0, 1, 0,  0, 32'hC, 2, 1, 0, 0);
      // Full throughput, sel cycling 0,1,2
      for (int k = 0; k < 10; k++)
         add(1, 2'(k % 3), 1, 0,  1, 32'hA + 32'(k % 3), 2'(k % 3), 1, 0, 0);
      add(0, 0, 1, 0,  0, 32'hA, 0, 1, 0, 0);
      // Invalid select, clear, set-wins-over-clear, clear
      add(1, 3, 1, 0,  0, 32'hA, 0, 1, 1, 1);
      add(0, 0, 1, 1,  0, 32'hA, 0, 1, 0, 0);
      add(1, 3, 1, 1,  0, 32'hA, 0, 1, 1, 1);
      add(0, 0, 1, 1,  0, 32'hA, 0, 1, 0, 0);
      // Invalid select while one entry held must not be queued
      add(1, 1, 0, 0,  1, 32'hB, 1, 1, 0, 0);
      add(1, 3, 0, 0,  1, 32'hB, 1, 1, 1, 1);
      add(0, 0, 1, 0,  0, 32'hB, 1, 1, 1, 1);
      add(0, 0, 1, 1,  0, 32'hB, 1, 1, 0, 0);

      foreach (vecs[i]) begin
         drive3(vecs[i].iv, vecs[i].sel, vecs[i].ordy, vecs[i].clr);
         step();
         chk("ov",   i, 32'(bus3.out_valid), 32'(vecs[i].ov));
         chk("dout", i, bus3.dout, vecs[i].dout);
         chk("osel", i, 32'(bus3.out_sel), 32'(vecs[i].osel));
         chk("ir",   i, 32'(bus3.in_ready), 32'(vecs[i].ir));
         chk("err",  i, 32'(bus3.err_invalid_sel), 32'(vecs[i].err));
`ifdef MUX_ERR_CNT_EN
         chk("cnt",  i, 32'(bus3.err_cnt), 32'(vecs[i].cnt));
`endif
      end

      // 300 invalid accepts: flag set, counter saturates
      drive3(1'b1, 2'd3, 1'b1, 1'b0);
      for (int k = 0; k < 300; k++) step();
      chk("sat_err", 0, 32'(bus3.err_invalid_sel), 32'd1);
      chk("sat_ov",  0, 32'(bus3.out_valid), 32'd0);
`ifdef MUX_ERR_CNT_EN
      chk("sat_cnt", 0, 32'(bus3.err_cnt), 32'd255);
`endif
      drive3(1'b0, 2'd0, 1'b1, 1'b1);
      step();
      chk("clr_err", 0, 32'(bus3.err_invalid_sel), 32'd0);
`ifdef MUX_ERR_CNT_EN
      chk("clr_cnt", 0, 32'(bus3.err_cnt), 32'd0);
`endif

      // Async reset while full with the error flag set
      drive3(1'b1, 2'd3, 1'b0, 1'b0);
      step();
      drive3(1'b1, 2'd0, 1'b0, 1'b0);
      step();
      drive3(1'b1, 2'd2, 1'b0, 1'b0);
      step();
      chk("pre_ir",   0, 32'(bus3.in_ready), 32'd0);
      chk("pre_err",  0, 32'(bus3.err_invalid_sel), 32'd1);
      chk("pre_dout", 0, bus3.dout, 32'hA);
      drive3(1'b0, 2'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_ov",   0, 32'(bus3.out_valid), 32'd0);
      chk("ar_dout", 0, bus3.dout, 32'd0);
      chk("ar_osel", 0, 32'(bus3.out_sel), 32'd0);
      chk("ar_err",  0, 32'(bus3.err_invalid_sel), 32'd0);
`ifdef MUX_ERR_CNT_EN
      chk("ar_cnt",  0, 32'(bus3.err_cnt), 32'd0);
`endif
      #1 rst_n = 1'b1;
      #1;
      chk("ar_ir", 0, 32'(bus3.in_ready), 32'd1);
      bus3.out_ready = 1'b1;
      step();
      chk("ar_ov_post", 0, 32'(bus3.out_valid), 32'd0);

      // Power-of-two N: sel=3 is a real channel
      bus4.in_valid  = 1'b1;
      bus4.sel       = 2'd3;
      bus4.out_ready = 1'b1;
      step();
      chk("n4_ov",   0, 32'(bus4.out_valid), 32'd1);
      chk("n4_dout", 0, bus4.dout, 32'hD);
      chk("n4_osel", 0, 32'(bus4.out_sel), 32'd3);
      chk("n4_err",  0, 32'(bus4.err_invalid_sel), 32'd0);
      bus4.in_valid = 1'b0;
      step();
      chk("n4_ov2",  1, 32'(bus4.out_valid), 32'd0);
      chk("n4_err2", 1, 32'(bus4.err_invalid_sel), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
